riscv_lsu: RTL and testbench

//  Load/store unit between the register file and the data memory. Takes the address

---
 rtl/riscv_lsu.sv | 164 ++++++++++++++++
 tb/tb_riscv_lsu.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit between the core and a req/ready byte-lane data memory.
// Define LSU_TIMEOUT_EN to abort a WAIT after TIMEOUT_CYCLES cycles with a fault pulse.
module riscv_lsu #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        lsu_req_i,
   input  logic        lsu_we_i,
   input  logic [2:0]  lsu_size_i,
   input  logic [31:0] lsu_addr_i,
   input  logic [31:0] lsu_wdata_i,
   output logic [31:0] lsu_rdata_o,
   output logic        lsu_stall_o,
   output logic        lsu_misalign_o,
   output logic        lsu_fault_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_ready_i
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      r_state;
   logic        r_mem_req;
   logic        r_mem_we;
   logic [3:0]  r_mem_be;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_wdata;
   logic [31:0] r_rdata;
   logic [2:0]  r_size;
   logic [1:0]  r_off;

   logic        w_illegal;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [31:0] w_shifted;
   logic [31:0] w_load;

   // NOTE: every signal written in an always_comb gets a default first, so no path infers a latch.
   always_comb begin
      w_illegal = 1'b0;
      w_be      = 4'b1111;
      w_wdata   = lsu_wdata_i;
      case (lsu_size_i)
         3'b000, 3'b100: begin
            w_be    = 4'b0001 << lsu_addr_i[1:0];
            w_wdata = {4{lsu_wdata_i[7:0]}};
         end
         3'b001, 3'b101: begin
            w_illegal = lsu_addr_i[0];
            w_be      = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
            w_wdata   = {2{lsu_wdata_i[15:0]}};
         end
         3'b010: w_illegal = |lsu_addr_i[1:0];
         default: w_illegal = 1'b1;
      endcase
   end

   // Load formatting uses the size and offset latched at request time.
   assign w_shifted = mem_rdata_i >> {r_off, 3'b000};

   always_comb begin
      w_load = w_shifted;
      case (r_size)
         3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
         3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
         3'b100:  w_load = {24'd0, w_shifted[7:0]};
         3'b101:  w_load = {16'd0, w_shifted[15:0]};
         default: w_load = w_shifted;
      endcase
   end

   assign lsu_misalign_o = lsu_req_i & w_illegal;
   assign lsu_stall_o    = lsu_req_i & ~lsu_misalign_o & (r_state != S_DONE);

`ifdef LSU_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);
   logic [7:0] r_cnt;
   logic       r_fault;
   assign lsu_fault_o = r_fault;
`else
   assign lsu_fault_o = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_be    <= 4'b0000;
         r_mem_addr  <= 32'd0;
         r_mem_wdata <= 32'd0;
         r_rdata     <= 32'd0;
         r_size      <= 3'd0;
         r_off       <= 2'd0;
`ifdef LSU_TIMEOUT_EN
         r_cnt       <= 8'd0;
         r_fault     <= 1'b0;
`endif
      end else begin
`ifdef LSU_TIMEOUT_EN
         r_fault <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               if (lsu_req_i && !w_illegal) begin
                  r_state     <= S_WAIT;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= lsu_we_i;
                  r_mem_be    <= w_be;
                  r_mem_addr  <= {lsu_addr_i[31:2], 2'b00};
                  r_mem_wdata <= w_wdata;
                  r_size      <= lsu_size_i;
                  r_off       <= lsu_addr_i[1:0];
`ifdef LSU_TIMEOUT_EN
                  r_cnt       <= 8'd0;
`endif
               end
            end
            S_WAIT: begin
               if (mem_ready_i) begin
                  if (!r_mem_we) r_rdata <= w_load;
                  r_state   <= S_DONE;
                  r_mem_req <= 1'b0;
                  r_mem_we  <= 1'b0;
                  r_mem_be  <= 4'b0000;
               end
`ifdef LSU_TIMEOUT_EN
               else if (r_cnt == TIMEOUT_LIM) begin
                  if (!r_mem_we) r_rdata <= 32'd0;
                  r_fault   <= 1'b1;
                  r_state   <= S_DONE;
                  r_mem_req <= 1'b0;
                  r_mem_we  <= 1'b0;
                  r_mem_be  <= 4'b0000;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
`endif
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign lsu_rdata_o = r_rdata;
   assign mem_req_o   = r_mem_req;
   assign mem_we_o    = r_mem_we;
   assign mem_be_o    = r_mem_be;
   assign mem_addr_o  = r_mem_addr;
   assign mem_wdata_o = r_mem_wdata;

endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: scenario tasks driving riscv_lsu against a bench-side memory responder.
// Expected load results are queued when a request is issued and popped when it completes.
module tb_riscv_lsu;

`ifdef LSU_TIMEOUT_EN
   localparam int unsigned TO_CYCLES = 4;
`else
   localparam int unsigned TO_CYCLES = 255;
`endif

   logic        clk;
   logic        rst_n;
   logic        lsu_req_i;
   logic        lsu_we_i;
   logic [2:0]  lsu_size_i;
   logic [31:0] lsu_addr_i;
   logic [31:0] lsu_wdata_i;
   logic [31:0] lsu_rdata_o;
   logic        lsu_stall_o;
   logic        lsu_misalign_o;
   logic        lsu_fault_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i;
   logic        mem_ready_i;

   int checks = 0;
   int errors = 0;
   logic [31:0] sb_q[$];
   logic [31:0] last_rdata;

   riscv_lsu #(.TIMEOUT_CYCLES(TO_CYCLES)) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .lsu_req_i      (lsu_req_i),
      .lsu_we_i       (lsu_we_i),
      .lsu_size_i     (lsu_size_i),
      .lsu_addr_i     (lsu_addr_i),
      .lsu_wdata_i    (lsu_wdata_i),
      .lsu_rdata_o    (lsu_rdata_o),
      .lsu_stall_o    (lsu_stall_o),
      .lsu_misalign_o (lsu_misalign_o),
      .lsu_fault_o    (lsu_fault_o),
      .mem_req_o      (mem_req_o),
      .mem_we_o       (mem_we_o),
      .mem_be_o       (mem_be_o),
      .mem_addr_o     (mem_addr_o),
      .mem_wdata_o    (mem_wdata_o),
      .mem_rdata_i    (mem_rdata_i),
      .mem_ready_i    (mem_ready_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Reference load formatting, written as byte/halfword selection.
   function automatic logic [31:0] model_load(input logic [2:0] size, input logic [1:0] off,
                                              input logic [31:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'd0: b = word[7:0];
         2'd1: b = word[15:8];
         2'd2: b = word[23:16];
         default: b = word[31:24];
      endcase
      h = off[1] ? word[31:16] : word[15:0];
      case (size)
         3'b000:  return {{24{b[7]}}, b};
         3'b100:  return {24'd0, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b101:  return {16'd0, h};
         default: return word;
      endcase
   endfunction

   function automatic logic [3:0] model_be(input logic [2:0] size, input logic [1:0] off);
      if (size == 3'b010) return 4'b1111;
      if (size[1:0] == 2'b01) return off[1] ? 4'b1100 : 4'b0011;
      case (off)
         2'd0: return 4'b0001;
         2'd1: return 4'b0010;
         2'd2: return 4'b0100;
         default: return 4'b1000;
      endcase
   endfunction

   // One complete access: ready arrives `delay` cycles after the request cycle.
   task automatic run_access(input string name, input logic we, input logic [2:0] size,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] mem_word, input int delay,
                             input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                             input logic [31:0] exp_rdata);
      int stalls;
      logic [31:0] exp;
      stalls = 0;
      @(posedge clk); #1;
      lsu_req_i   = 1'b1;
      lsu_we_i    = we;
      lsu_size_i  = size;
      lsu_addr_i  = addr;
      lsu_wdata_i = wdata;
      mem_ready_i = 1'b0;
      sb_q.push_back(we ? last_rdata : exp_rdata);
      @(negedge clk);
      if (lsu_stall_o) stalls++;
      checks++;
      if (lsu_misalign_o !== 1'b0 || mem_req_o !== 1'b0) begin
         errors++;
         $display("FAIL %s_issue misalign=%b mem_req=%b, want 0 0", name, lsu_misalign_o, mem_req_o);
      end
      for (int c = 1; c <= delay; c++) begin
         @(posedge clk); #1;
         if (c == delay) begin
            mem_ready_i = 1'b1;
            mem_rdata_i = mem_word;
         end else begin
            mem_rdata_i = $urandom;
         end
         @(negedge clk);
         if (lsu_stall_o) stalls++;
         checks++;
         if (mem_req_o !== 1'b1 || mem_we_o !== we || mem_be_o !== exp_be ||
             mem_addr_o !== {addr[31:2], 2'b00} || (we && mem_wdata_o !== exp_wdata)) begin
            errors++;
            $display("FAIL %s_bus cyc%0d req=%b we=%b be=%b addr=%h wdata=%h, want 1 %b %b %h %h",
                     name, c, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
                     we, exp_be, {addr[31:2], 2'b00}, exp_wdata);
         end
      end
      @(posedge clk); #1;
      mem_ready_i = 1'b0;
      mem_rdata_i = $urandom;
      @(negedge clk);
      if (lsu_stall_o) stalls++;
      exp = sb_q.pop_front();
      checks++;
      if (lsu_rdata_o !== exp || mem_req_o !== 1'b0) begin
         errors++;
         $display("FAIL %s_result rdata=%h mem_req=%b, want %h 0", name, lsu_rdata_o, mem_req_o, exp);
      end
      last_rdata = exp;
      checks++;
      if (stalls != delay + 1) begin
         errors++;
         $display("FAIL %s_stall_cycles got %0d want %0d", name, stalls, delay + 1);
      end
      @(posedge clk); #1;
      lsu_req_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = 3'b010;
      lsu_addr_i = 32'd0; lsu_wdata_i = 32'd0;
      mem_rdata_i = 32'd0; mem_ready_i = 1'b0;
      last_rdata = 32'd0;
      repeat (3) @(negedge clk);
      checks++;
      if (mem_req_o !== 1'b0 || mem_we_o !== 1'b0 || mem_be_o !== 4'b0000 ||
          lsu_rdata_o !== 32'd0 || lsu_fault_o !== 1'b0 || lsu_stall_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_state req=%b we=%b be=%b rdata=%h fault=%b stall=%b, want all 0",
                  mem_req_o, mem_we_o, mem_be_o, lsu_rdata_o, lsu_fault_o, lsu_stall_o);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_loads();
      run_access("lw_100", 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1, 4'b1111, 32'h0, 32'hDEADBEEF);
      run_access("lb_103", 1'b0, 3'b000, 32'h103, 32'h0, 32'h80112233, 1, 4'b1000, 32'h0, 32'hFFFFFF80);
      run_access("lbu_103", 1'b0, 3'b100, 32'h103, 32'h0, 32'h80112233, 1, 4'b1000, 32'h0, 32'h00000080);
      run_access("lh_102", 1'b0, 3'b001, 32'h102, 32'h0, 32'h80112233, 2, 4'b1100, 32'h0, 32'hFFFF8011);
      run_access("lhu_100", 1'b0, 3'b101, 32'h100, 32'h0, 32'h1234F678, 1, 4'b0011, 32'h0, 32'h0000F678);
      run_access("lb_101", 1'b0, 3'b000, 32'h101, 32'h0, 32'h00007F00, 1, 4'b0010, 32'h0, 32'h0000007F);
      run_access("lw_slow", 1'b0, 3'b010, 32'h104, 32'h0, 32'h13579BDF, 3, 4'b1111, 32'h0, 32'h13579BDF);
   endtask

   task automatic test_stores();
      run_access("sh_202", 1'b1, 3'b001, 32'h202, 32'h0000ABCD, 32'hFFFFFFFF, 1, 4'b1100, 32'hABCDABCD, 32'h0);
      run_access("sb_301", 1'b1, 3'b000, 32'h301, 32'h123456A5, 32'hFFFFFFFF, 2, 4'b0010, 32'hA5A5A5A5, 32'h0);
      run_access("sw_404", 1'b1, 3'b010, 32'h404, 32'hCAFEF00D, 32'hFFFFFFFF, 1, 4'b1111, 32'hCAFEF00D, 32'h0);
   endtask

   task automatic test_random_loads();
      logic [2:0] sizes [5];
      sizes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      for (int i = 0; i < 10; i++) begin
         logic [2:0]  sz;
         logic [1:0]  off;
         logic [31:0] word;
         sz   = sizes[$urandom_range(0, 4)];
         off  = 2'($urandom_range(0, 3));
         if (sz == 3'b010) off = 2'd0;
         if (sz[1:0] == 2'b01) off[0] = 1'b0;
         word = $urandom;
         run_access("rand_ld", 1'b0, sz, {20'h00010, 10'($urandom), off}, 32'h0, word,
                    $urandom_range(1, 3), model_be(sz, off), 32'h0, model_load(sz, off, word));
      end
   endtask

   task automatic test_misalign();
      logic [2:0]  bad_size [7];
      logic [31:0] bad_addr [7];
      bad_size = '{3'b010, 3'b010, 3'b001, 3'b101, 3'b011, 3'b110, 3'b111};
      bad_addr = '{32'h102, 32'h101, 32'h101, 32'h203, 32'h100, 32'h100, 32'h100};
      for (int i = 0; i < 7; i++) begin
         @(posedge clk); #1;
         lsu_req_i = 1'b1; lsu_we_i = i[0]; lsu_size_i = bad_size[i]; lsu_addr_i = bad_addr[i];
         @(negedge clk);
         checks++;
         if (lsu_misalign_o !== 1'b1 || lsu_stall_o !== 1'b0) begin
            errors++;
            $display("FAIL misalign_%0d misalign=%b stall=%b, want 1 0", i, lsu_misalign_o, lsu_stall_o);
         end
         @(negedge clk);
         checks++;
         if (mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL misalign_noreq_%0d mem_req=%b, want 0", i, mem_req_o);
         end
         @(posedge clk); #1;
         lsu_req_i = 1'b0;
      end
   endtask

   task automatic test_req_drop();
      logic [31:0] exp;
      @(posedge clk); #1;
      lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'b010; lsu_addr_i = 32'h600;
      sb_q.push_back(32'h0BADF00D);
      @(posedge clk); #1;
      lsu_req_i = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_req_o !== 1'b1) begin
         errors++;
         $display("FAIL req_drop_hold mem_req=%b, want 1", mem_req_o);
      end
      @(posedge clk); #1;
      mem_ready_i = 1'b1; mem_rdata_i = 32'h0BADF00D;
      @(posedge clk); #1;
      mem_ready_i = 1'b0;
      @(negedge clk);
      exp = sb_q.pop_front();
      checks++;
      if (lsu_rdata_o !== exp || mem_req_o !== 1'b0) begin
         errors++;
         $display("FAIL req_drop_result rdata=%h mem_req=%b, want %h 0", lsu_rdata_o, mem_req_o, exp);
      end
      last_rdata = exp;
   endtask

   task automatic test_ready_outside_wait();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         mem_ready_i = 1'b1; mem_rdata_i = $urandom;
         @(negedge clk);
         checks++;
         if (mem_req_o !== 1'b0 || lsu_rdata_o !== last_rdata) begin
            errors++;
            $display("FAIL stray_ready_%0d mem_req=%b rdata=%h, want 0 %h", i, mem_req_o, lsu_rdata_o, last_rdata);
         end
      end
      @(posedge clk); #1;
      mem_ready_i = 1'b0;
   endtask

   task automatic test_reset_mid_wait();
      @(posedge clk); #1;
      lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'b010; lsu_addr_i = 32'h700;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (mem_req_o !== 1'b1) begin
         errors++;
         $display("FAIL rst_wait_entry mem_req=%b, want 1", mem_req_o);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (mem_req_o !== 1'b0 || lsu_rdata_o !== 32'd0 || mem_be_o !== 4'b0000) begin
         errors++;
         $display("FAIL rst_async req=%b rdata=%h be=%b, want 0 0 0", mem_req_o, lsu_rdata_o, mem_be_o);
      end
      lsu_req_i = 1'b0;
      last_rdata = 32'd0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (mem_req_o !== 1'b0 || lsu_stall_o !== 1'b0) begin
         errors++;
         $display("FAIL rst_idle req=%b stall=%b, want 0 0", mem_req_o, lsu_stall_o);
      end
      run_access("post_rst", 1'b0, 3'b101, 32'h702, 32'h0, 32'h8001FFFF, 1, 4'b1100, 32'h0, 32'h00008001);
   endtask

   task automatic test_timeout();
`ifdef LSU_TIMEOUT_EN
      int   pulses;
      logic released;
      logic [31:0] exp;
      pulses = 0;
      released = 1'b0;
      @(posedge clk); #1;
      lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'b010; lsu_addr_i = 32'h800;
      mem_ready_i = 1'b0;
      sb_q.push_back(32'd0);
      for (int c = 0; c < 30 && !released; c++) begin
         @(negedge clk);
         if (lsu_fault_o) pulses++;
         if (!lsu_stall_o) released = 1'b1;
      end
      checks++;
      if (released !== 1'b1) begin
         errors++;
         $display("FAIL timeout_release stall never dropped within 30 cycles");
      end
      exp = sb_q.pop_front();
      checks++;
      if (lsu_rdata_o !== exp || mem_req_o !== 1'b0) begin
         errors++;
         $display("FAIL timeout_result rdata=%h mem_req=%b, want %h 0", lsu_rdata_o, mem_req_o, exp);
      end
      last_rdata = exp;
      @(posedge clk); #1;
      lsu_req_i = 1'b0;
      @(negedge clk);
      if (lsu_fault_o) pulses++;
      checks++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL timeout_pulse got %0d fault cycles, want 1", pulses);
      end
`else
      run_access("no_timeout", 1'b0, 3'b010, 32'h800, 32'h0, 32'h2468ACE0, 10, 4'b1111, 32'h0, 32'h2468ACE0);
      checks++;
      if (lsu_fault_o !== 1'b0) begin
         errors++;
         $display("FAIL fault_tied fault=%b, want 0", lsu_fault_o);
      end
`endif
   endtask

   task automatic test_back_to_back();
      run_access("b2b_sw", 1'b1, 3'b010, 32'h900, 32'h11223344, 32'h0, 1, 4'b1111, 32'h11223344, 32'h0);
      run_access("b2b_lh", 1'b0, 3'b001, 32'h900, 32'h0, 32'h11223344, 1, 4'b0011, 32'h0, 32'h00003344);
      run_access("b2b_sb", 1'b1, 3'b100, 32'h902, 32'h000000EE, 32'h0, 1, 4'b0100, 32'hEEEEEEEE, 32'h0);
   endtask

   initial begin
      test_reset();
      test_loads();
      test_stores();
      test_random_loads();
      test_misalign();
      test_req_drop();
      test_ready_outside_wait();
      test_back_to_back();
      test_timeout();
      test_reset_mid_wait();
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
